// File: rtl/wb_arbiter_stage_if.sv
// Writeback stage bus: pipeline retire port, long-latency result port and the
// register-file write port. Both input ports use valid/ready (see stage header).
interface wb_arbiter_stage_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
);
  logic              in_valid;
  logic              in_ready;
  logic              in_regwrite;
  logic [REG_AW-1:0] in_rd;
  logic [1:0]        in_wsel;
  logic [2:0]        in_funct3;
  logic [1:0]        in_addr_lo;
  logic [XLEN-1:0]   in_alu;
  logic [XLEN-1:0]   in_load_word;
  logic [XLEN-1:0]   in_pc4;

  logic              lu_valid;
  logic              lu_ready;
  logic [REG_AW-1:0] lu_rd;
  logic [XLEN-1:0]   lu_data;

  logic              we;
  logic [REG_AW-1:0] rd_addr;
  logic [XLEN-1:0]   rd_data;
  logic              buf_busy;
  logic [REG_AW-1:0] buf_rd;

  modport slave (
    input  in_valid, in_regwrite, in_rd, in_wsel, in_funct3, in_addr_lo,
           in_alu, in_load_word, in_pc4, lu_valid, lu_rd, lu_data,
    output in_ready, lu_ready, we, rd_addr, rd_data, buf_busy, buf_rd
  );

  modport master (
    output in_valid, in_regwrite, in_rd, in_wsel, in_funct3, in_addr_lo,
           in_alu, in_load_word, in_pc4, lu_valid, lu_rd, lu_data,
    input  in_ready, lu_ready, we, rd_addr, rd_data, buf_busy, buf_rd
  );
endinterface

// File: rtl/wb_arbiter_stage.sv
// Writeback arbiter: merges in-order pipeline results and a 1-entry buffered
// long-latency result onto the single register-file write port.
module wb_arbiter_stage #(
  parameter int XLEN         = 32,
  parameter int REG_AW       = 5,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  wb_arbiter_stage_if.slave   bus
);
  // Handshake: a transfer happens on a rising edge where valid && ready are both
  // high; ready never depends on valid in this stage, and the source holds its
  // payload stable while valid is high and ready is low.
  localparam int AGE_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  logic              buf_full;
  logic [REG_AW-1:0] buf_rd_q;
  logic [XLEN-1:0]   buf_data;
  logic [AGE_W-1:0]  age;

  logic              we_q;
  logic [REG_AW-1:0] rd_addr_q;
  logic [XLEN-1:0]   rd_data_q;

  logic              in_ready;
  logic              lu_ready;
  logic              lu_acc;
  logic              pw;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [XLEN-1:0]   load_data;
  logic [XLEN-1:0]   pipe_data;

  assign in_ready = (age < AGE_W'(STARVE_LIMIT));
  assign lu_ready = ~buf_full;
  assign lu_acc   = bus.lu_valid && lu_ready;
  assign pw       = bus.in_valid && in_ready && bus.in_regwrite &&
                    (bus.in_wsel != 2'b11) && (bus.in_rd != '0);

  always_comb begin
    ld_byte   = bus.in_load_word[7:0];
    ld_half   = bus.in_addr_lo[1] ? bus.in_load_word[31:16] : bus.in_load_word[15:0];
    load_data = bus.in_load_word;
    pipe_data = bus.in_pc4;
    case (bus.in_addr_lo)
      2'd0:    ld_byte = bus.in_load_word[7:0];
      2'd1:    ld_byte = bus.in_load_word[15:8];
      2'd2:    ld_byte = bus.in_load_word[23:16];
      default: ld_byte = bus.in_load_word[31:24];
    endcase
    // Unlisted funct3 encodings fall through as a full-word load.
    case (bus.in_funct3)
      3'b000:  load_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b001:  load_data = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b100:  load_data = {{(XLEN-8){1'b0}}, ld_byte};
      3'b101:  load_data = {{(XLEN-16){1'b0}}, ld_half};
      default: load_data = bus.in_load_word;
    endcase
    case (bus.in_wsel)
      2'b00:   pipe_data = bus.in_alu;
      2'b01:   pipe_data = load_data;
      default: pipe_data = bus.in_pc4;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q      <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
      buf_full  <= 1'b0;
      buf_rd_q  <= '0;
      buf_data  <= '0;
      age       <= '0;
    end else begin
      if (pw) begin
        we_q      <= 1'b1;
        rd_addr_q <= bus.in_rd;
        rd_data_q <= pipe_data;
      end else if (buf_full) begin
        // A buffered x0 result is retired silently so x0 is never written.
        we_q <= (buf_rd_q != '0);
        if (buf_rd_q != '0) begin
          rd_addr_q <= buf_rd_q;
          rd_data_q <= buf_data;
        end
      end else begin
        we_q <= 1'b0;
      end

      // lu_acc implies the buffer is empty, so load and drain never coincide.
      if (lu_acc) begin
        buf_full <= 1'b1;
        buf_rd_q <= bus.lu_rd;
        buf_data <= bus.lu_data;
        age      <= '0;
      end else if (buf_full && !pw) begin
        buf_full <= 1'b0;
        age      <= '0;
      end else if (buf_full) begin
        age <= age + AGE_W'(1);
      end
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.lu_ready = lu_ready;
  assign bus.we       = we_q;
  assign bus.rd_addr  = rd_addr_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.buf_busy = buf_full;
  assign bus.buf_rd   = buf_rd_q;
endmodule

// File: tb/tb_wb_arbiter_stage.sv
// Directed bench for wb_arbiter_stage: register-file writes are checked in
// order against an expected queue; handshake/buffer state checked per step.
module tb_wb_arbiter_stage;
  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int WW     = REG_AW + XLEN;

  logic clk;
  logic rst_n;

  wb_arbiter_stage_if #(.XLEN(XLEN), .REG_AW(REG_AW)) bus ();

  wb_arbiter_stage #(.XLEN(XLEN), .REG_AW(REG_AW), .STARVE_LIMIT(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  logic [WW-1:0] exp_q[$];
  logic [WW-1:0] exp_w;
  int            n_checks;
  int            n_fail;
  int            n;
  int            cyc;
  logic          rdy_before;
  logic          exp_rdy [0:6];

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [REG_AW-1:0] rd, input logic [XLEN-1:0] data);
    exp_q.push_back({rd, data});
  endtask

  task automatic idle_inputs();
    bus.in_valid     = 1'b0;
    bus.in_regwrite  = 1'b1;
    bus.in_rd        = '0;
    bus.in_wsel      = 2'b00;
    bus.in_funct3    = 3'b010;
    bus.in_addr_lo   = 2'b00;
    bus.in_alu       = '0;
    bus.in_load_word = '0;
    bus.in_pc4       = '0;
    bus.lu_valid     = 1'b0;
    bus.lu_rd        = '0;
    bus.lu_data      = '0;
  endtask

  task automatic pipe(input logic [REG_AW-1:0] rd, input logic [1:0] wsel,
                      input logic [2:0] f3, input logic [1:0] lo,
                      input logic [XLEN-1:0] alu, input logic [XLEN-1:0] word,
                      input logic [XLEN-1:0] pc4);
    bus.in_valid     = 1'b1;
    bus.in_regwrite  = 1'b1;
    bus.in_rd        = rd;
    bus.in_wsel      = wsel;
    bus.in_funct3    = f3;
    bus.in_addr_lo   = lo;
    bus.in_alu       = alu;
    bus.in_load_word = word;
    bus.in_pc4       = pc4;
  endtask

  task automatic load_step(input string tag, input logic [REG_AW-1:0] rd,
                           input logic [2:0] f3, input logic [1:0] lo,
                           input logic [XLEN-1:0] exp);
    pipe(rd, 2'b01, f3, lo, 32'h0, 32'h80FF7F01, 32'h0);
    push(rd, exp);
    tick();
    chk(tag, bus.rd_data, exp);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp_rdy[0] = 1'b1; exp_rdy[1] = 1'b1; exp_rdy[2] = 1'b1; exp_rdy[3] = 1'b0;
    exp_rdy[4] = 1'b1; exp_rdy[5] = 1'b1; exp_rdy[6] = 1'b1;
    idle_inputs();
    rst_n = 1'b0;
    #12;
    chk("rst_we", bus.we, 1'b0);
    chk("rst_rd_addr", bus.rd_addr, 5'd0);
    chk("rst_rd_data", bus.rd_data, 32'd0);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_lu_ready", bus.lu_ready, 1'b1);
    chk("rst_buf_busy", bus.buf_busy, 1'b0);
    chk("rst_buf_rd", bus.buf_rd, 5'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // scoreboard: every register-file write must match the next expected entry
    fork
      forever begin
        @(negedge clk);
        if (rst_n === 1'b1 && bus.we === 1'b1) begin
          n_checks++;
          assert (exp_q.size() > 0) else begin
            n_fail++;
            $error("FAIL unexpected_write: observed rd %0d data 0x%0h expected no write",
                   bus.rd_addr, bus.rd_data);
          end
          if (exp_q.size() > 0) begin
            exp_w = exp_q.pop_front();
            chk("rf_write", {bus.rd_addr, bus.rd_data}, exp_w);
          end
        end
      end
    join_none

    // ALU writeback
    pipe(5'd5, 2'b00, 3'b010, 2'b00, 32'd42, 32'h0, 32'h0);
    push(5'd5, 32'd42);
    tick();
    chk("alu_we", bus.we, 1'b1);
    chk("alu_rd_addr", bus.rd_addr, 5'd5);
    chk("alu_rd_data", bus.rd_data, 32'd42);

    // load extension
    load_step("lb_lo1", 5'd10, 3'b000, 2'd1, 32'h0000007F);
    load_step("lb_lo3", 5'd11, 3'b000, 2'd3, 32'hFFFFFF80);
    load_step("lhu_lo2", 5'd12, 3'b101, 2'd2, 32'h000080FF);
    load_step("lh_lo2", 5'd13, 3'b001, 2'd2, 32'hFFFF80FF);
    load_step("lbu_lo0", 5'd17, 3'b100, 2'd0, 32'h00000001);
    load_step("lw", 5'd18, 3'b010, 2'd0, 32'h80FF7F01);

    // PC+4, then writes that must be suppressed
    pipe(5'd14, 2'b10, 3'b010, 2'b00, 32'h0, 32'h0, 32'h1004);
    push(5'd14, 32'h1004);
    tick();
    chk("pc4_rd_data", bus.rd_data, 32'h1004);
    pipe(5'd15, 2'b11, 3'b010, 2'b00, 32'd7, 32'h0, 32'h0);
    tick();
    chk("wsel11_we", bus.we, 1'b0);
    pipe(5'd16, 2'b00, 3'b010, 2'b00, 32'd5, 32'h0, 32'h0);
    bus.in_regwrite = 1'b0;
    tick();
    chk("noregwrite_we", bus.we, 1'b0);
    pipe(5'd0, 2'b00, 3'b010, 2'b00, 32'd999, 32'h0, 32'h0);
    tick();
    chk("x0_we", bus.we, 1'b0);
    chk("x0_hold_addr", bus.rd_addr, 5'd14);
    chk("x0_hold_data", bus.rd_data, 32'h1004);
    bus.in_valid = 1'b0;

    // buffered x0 result is drained without a write
    bus.lu_valid = 1'b1; bus.lu_rd = 5'd0; bus.lu_data = 32'd55;
    tick();
    chk("lux0_busy", bus.buf_busy, 1'b1);
    chk("lux0_lu_ready", bus.lu_ready, 1'b0);
    chk("lux0_we_cap", bus.we, 1'b0);
    bus.lu_valid = 1'b0;
    tick();
    chk("lux0_drained", bus.buf_busy, 1'b0);
    chk("lux0_we_drain", bus.we, 1'b0);
    chk("lux0_lu_ready2", bus.lu_ready, 1'b1);

    // idle drain
    bus.lu_valid = 1'b1; bus.lu_rd = 5'd7; bus.lu_data = 32'd123;
    tick();
    chk("idle_busy", bus.buf_busy, 1'b1);
    chk("idle_buf_rd", bus.buf_rd, 5'd7);
    chk("idle_we_cap", bus.we, 1'b0);
    bus.lu_valid = 1'b0;
    push(5'd7, 32'd123);
    tick();
    chk("idle_we", bus.we, 1'b1);
    chk("idle_rd_addr", bus.rd_addr, 5'd7);
    chk("idle_rd_data", bus.rd_data, 32'd123);
    chk("idle_lu_ready", bus.lu_ready, 1'b1);

    // starvation: buffered rd 9 must slip in after three pipeline writes
    push(5'd1, 32'd101); push(5'd2, 32'd102); push(5'd3, 32'd103);
    push(5'd4, 32'd104); push(5'd9, 32'h900); push(5'd5, 32'd105);
    push(5'd6, 32'd106);
    bus.lu_valid = 1'b1; bus.lu_rd = 5'd9; bus.lu_data = 32'h900;
    n = 1;
    cyc = 0;
    while (n <= 6 && cyc < 20) begin
      pipe(REG_AW'(n), 2'b00, 3'b010, 2'b00, XLEN'(100 + n), 32'h0, 32'h0);
      rdy_before = bus.in_ready;
      tick();
      bus.lu_valid = 1'b0;
      if (cyc < 7) chk("starve_in_ready", bus.in_ready, exp_rdy[cyc]);
      if (cyc == 4) begin
        chk("starve_drain_we", bus.we, 1'b1);
        chk("starve_drain_rd", bus.rd_addr, 5'd9);
      end
      if (rdy_before) n++;
      cyc++;
    end
    chk("starve_accepts", n, 7);
    chk("starve_cycles", cyc, 7);
    bus.in_valid = 1'b0;

    // asynchronous reset with the buffer full and a write pending
    pipe(5'd3, 2'b00, 3'b010, 2'b00, 32'd77, 32'h0, 32'h0);
    bus.lu_valid = 1'b1; bus.lu_rd = 5'd20; bus.lu_data = 32'hABC;
    push(5'd3, 32'd77);
    tick();
    bus.lu_valid = 1'b0;
    bus.in_valid = 1'b0;
    chk("prerst_busy", bus.buf_busy, 1'b1);
    chk("prerst_we", bus.we, 1'b1);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_we", bus.we, 1'b0);
    chk("arst_lu_ready", bus.lu_ready, 1'b1);
    chk("arst_busy", bus.buf_busy, 1'b0);
    chk("arst_buf_rd", bus.buf_rd, 5'd0);
    chk("arst_rd_addr", bus.rd_addr, 5'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("postrst_we", bus.we, 1'b0);
    chk("postrst_busy", bus.buf_busy, 1'b0);

    tick();
    tick();
    chk("exp_q_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
